// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among NUM_REQ requesters.
// One transaction in flight; a watchdog force-completes a transaction the memory never answers.
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [31:0]               req_rdata,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_wdog;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_wstrb;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic               w_busy;
  logic               w_wd_hit;
  logic               w_done;

  // Rotating scan starting just after the last winner.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  assign w_busy   = (r_state == BUSY);
  assign w_wd_hit = (TIMEOUT != 0) && (r_wdog == WD_LAST);
  // A watchdog hit that coincides with mem_ready is an ordinary completion.
  assign w_done   = w_busy && (mem_ready || w_wd_hit);

  always_comb begin
    req_ready = '0;
    if (w_done) req_ready[r_grant] = 1'b1;
  end

  assign req_rdata   = (w_busy && mem_ready) ? mem_rdata : 32'h0;
  assign timeout_err = w_busy && !mem_ready && w_wd_hit;
  assign mem_valid   = w_busy;
  assign busy        = w_busy;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign grant_idx   = r_grant;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_wdog      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_mem_addr  <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
            r_mem_wdata <= req_wdata[int'(w_pick)*32 +: 32];
            r_mem_wstrb <= req_wstrb[int'(w_pick)*4 +: 4];
            r_grant     <= w_pick;
            r_wdog      <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one valid/ready memory port between NUM_REQ requesters, e.g. CPU fetch/data, DMA and video refill.
- Round-robin arbitration; one transaction in flight at a time.
- Captures the winning request into registers and drives the shared port from them.
- Sits between the multicycle core's bus masters and the SoC memory/IO interconnect; includes a watchdog that terminates hung transactions.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- TIMEOUT, 1024, cycles in BUSY without mem_ready before forced termination; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*32  flattened write data.
- req_wstrb  in  NUM_REQ*4  flattened byte strobes; 0 means read.
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data broadcast; meaningful only while some req_ready bit is 1.
- mem_valid  out  1  shared port request.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  32  registered write data.
- mem_wstrb  out  4  registered strobes.
- mem_ready  in  1  shared port completion.
- mem_rdata  in  32  shared port read data.
- grant_idx  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in BUSY.
- timeout_err  out  1  one-cycle pulse on watchdog termination.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; mem_valid=0; mem_addr/mem_wdata/mem_wstrb=0; req_ready=0; timeout_err=0; busy=0; grant_idx=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-transaction abandons it: mem_valid=0 the next cycle, no req_ready is issued, and the memory side is not waited on.
- FSM states are IDLE and BUSY.
- IDLE:
  - If req_valid≠0, select the first set bit scanning last+1, last+2, … modulo NUM_REQ.
  - Register that requester's addr/wdata/wstrb into mem_*; set grant_idx; clear the watchdog counter; go to BUSY.
  - No req_valid: stay in IDLE.
- BUSY:
  - mem_valid=1 and busy=1; mem_* are held constant.
  - Requester inputs are ignored while in BUSY; dropping or changing them does not affect the transaction.
- Completion:
  - In a BUSY cycle with mem_ready=1: req_ready[grant_idx]=1 and req_rdata=mem_rdata in the same cycle (combinational).
  - Next cycle: IDLE, last=grant_idx, mem_valid=0.
- Watchdog:
  - The counter increments each BUSY cycle without mem_ready.
  - When TIMEOUT≠0 and the counter equals TIMEOUT-1 with mem_ready=0: req_ready[grant_idx]=1, req_rdata=0, timeout_err=1 that cycle; next cycle IDLE, last updated.
  - If mem_ready and the timeout coincide, this is a normal completion: real rdata and timeout_err=0.
- Latency and throughput:
  - Request seen in IDLE at cycle N gives mem_valid at N+1.
  - Zero-wait memory (mem_ready in the first BUSY cycle) completes at N+1.
  - Minimum one IDLE cycle between transactions; peak throughput is one transaction per 2 cycles.
- Outside completion cycles, req_ready=0 and req_rdata=0.
- A requester must hold req_valid until its req_ready. If it is still high after ready, that is a new request.
- Simultaneous events: new requests arriving during BUSY wait. The completion cycle does not arbitrate; the next arbitration happens in the following IDLE cycle using the updated last.
- Starvation bound: with all requesters continuously valid, each is granted once per NUM_REQ transactions.

Test Plan:
- Single read, zero wait: after reset, req_valid=01, addr0=0x1000, wstrb0=0, mem_ready high in the first BUSY cycle with rdata 0xDEADBEEF -> mem_valid one cycle later with mem_addr=0x1000; req_ready=01 and req_rdata=0xDEADBEEF in that same cycle; IDLE next.
- Contention, NUM_REQ=3: all valid continuously, 2-cycle memory -> grant order 0,1,2,0,1,2; each req_ready pulse reaches only its owner; gaps exactly one IDLE cycle.
- Write capture: requester 1 issues wstrb=0x3, wdata=0x12345678, addr=0x2004, then changes its inputs during BUSY -> mem_* stay 0x2004/0x12345678/0x3 until mem_ready.
- Watchdog, TIMEOUT=8: mem_ready never asserted -> in the 8th BUSY cycle req_ready[g]=1, req_rdata=0, timeout_err=1; IDLE next; a later request is served normally.
- Timeout coincident with mem_ready on the 8th cycle -> timeout_err=0; rdata passed through.
- Reset mid-BUSY: rst=1 in BUSY cycle 2 -> next cycle mem_valid=0, req_ready=0, grant_idx=0; with both requesters valid, requester 0 wins first afterwards.
